hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 59 +++++
 tb/tb_hazard_scoreboard.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: decode/execute/writeback handshake bundle for the hazard scoreboard
interface hazard_if;
   logic        dec_valid;
   logic [4:0]  dec_r1_reg;
   logic [4:0]  dec_r2_reg;
   logic        dec_uses_r1;
   logic        dec_uses_r2;
   logic [4:0]  dec_dst_reg;
   logic        dec_ecall;
   logic        ex_ready;
   logic        wb_valid;
   logic [4:0]  wb_dst_reg;
   logic        flush;
   logic        issue;
   logic        stall;
   logic [31:0] pending_mask;
   logic [2:0]  inflight;
   logic [1:0]  state;
   logic        err;
   modport master (
      output dec_valid, dec_r1_reg, dec_r2_reg, dec_uses_r1, dec_uses_r2, dec_dst_reg, dec_ecall,
      output ex_ready, wb_valid, wb_dst_reg, flush,
      input  issue, stall, pending_mask, inflight, state, err
   );
   modport slave (
      input  dec_valid, dec_r1_reg, dec_r2_reg, dec_uses_r1, dec_uses_r2, dec_dst_reg, dec_ecall,
      input  ex_ready, wb_valid, wb_dst_reg, flush,
      output issue, stall, pending_mask, inflight, state, err
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order issue gate tracking pending destination registers and ECALL serialisation
module hazard_scoreboard #(
   parameter int MAX_INFLIGHT = 4
) (
   input logic     clk,
   input logic     reset,
   hazard_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, ECALL_WAIT = 2'd2} state_e;
   state_e      state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [2:0]  inflight_q, inflight_d;
   logic        err_q, err_d;
   logic        raw, waw, full, idle, ecall_req, issue, wb_ok;
   // Issue decision: hazards are judged only against registered tracking state, so a retire unblocks next cycle
   always_comb begin
      raw = (bus.dec_uses_r1 & (bus.dec_r1_reg != 5'd0) & pending_q[bus.dec_r1_reg]) |
            (bus.dec_uses_r2 & (bus.dec_r2_reg != 5'd0) & pending_q[bus.dec_r2_reg]);
      waw = (bus.dec_dst_reg != 5'd0) & pending_q[bus.dec_dst_reg];
      full = inflight_q == 3'(MAX_INFLIGHT);
      idle = inflight_q == 3'd0;
      ecall_req = bus.dec_valid & bus.dec_ecall & ~bus.flush;
      issue = ~reset & (state_q == RUN   ? (ecall_req ? bus.ex_ready & idle
                                                      : bus.dec_valid & bus.ex_ready & ~raw & ~waw & ~full & ~bus.flush) :
                        state_q == DRAIN ? ecall_req & bus.ex_ready & idle : 1'b0);
   end
   // Tracking update: flush wipes everything, an illegal retire only raises the sticky error
   always_comb begin
      wb_ok = bus.wb_valid & ~idle & ((bus.wb_dst_reg == 5'd0) | pending_q[bus.wb_dst_reg]);
      err_d = err_q | (bus.wb_valid & ~wb_ok & ~bus.flush);
      inflight_d = bus.flush ? 3'd0 : inflight_q + 3'(issue) - 3'(wb_ok);
      pending_d = bus.flush ? 32'd0 : (pending_q & ~(32'(wb_ok) << bus.wb_dst_reg)) | (32'(issue) << bus.dec_dst_reg);
      pending_d[0] = 1'b0;
      state_d = bus.flush            ? RUN :
                state_q == RUN        ? (ecall_req ? (issue ? ECALL_WAIT : DRAIN) : RUN) :
                state_q == DRAIN      ? (issue ? ECALL_WAIT : ecall_req ? DRAIN : RUN) :
                state_q == ECALL_WAIT ? (inflight_d == 3'd0 ? RUN : ECALL_WAIT) : RUN;
   end
   // State register with synchronous reset discarding all in-flight tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         pending_q  <= 32'd0;
         inflight_q <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end
   assign bus.issue        = issue;
   assign bus.stall        = bus.dec_valid & ~issue;
   assign bus.pending_mask = pending_q;
   assign bus.inflight     = inflight_q;
   assign bus.state        = state_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic checked against a register-set model
module tb_hazard_scoreboard;
   localparam int MAXI = 4;
   localparam int M_RUN = 0, M_DRAIN = 1, M_EW = 2;
   logic clk = 1'b0;
   logic reset;
   hazard_if bus();
   hazard_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_err = 0;
   bit pend[32];
   int cnt, mode;
   bit err_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_mask();
      logic [31:0] m = '0;
      for (int i = 0; i < 32; i++) m[i] = pend[i];
      return m;
   endfunction

   function automatic bit m_issue();
      bit ec, hz;
      if (reset) return 1'b0;
      ec = bus.dec_valid && bus.dec_ecall;
      hz = (bus.dec_uses_r1 && bus.dec_r1_reg != 0 && pend[bus.dec_r1_reg]) ||
           (bus.dec_uses_r2 && bus.dec_r2_reg != 0 && pend[bus.dec_r2_reg]) ||
           (bus.dec_dst_reg != 0 && pend[bus.dec_dst_reg]);
      if (bus.flush) return 1'b0;
      if (mode == M_RUN) return ec ? (bus.ex_ready && cnt == 0) : (bus.dec_valid && bus.ex_ready && !hz && cnt < MAXI);
      if (mode == M_DRAIN) return ec && bus.ex_ready && cnt == 0;
      return 1'b0;
   endfunction

   task automatic m_step(input bit iss);
      bit ok;
      if (reset) begin
         foreach (pend[i]) pend[i] = 0;
         cnt = 0; mode = M_RUN; err_m = 0;
      end else if (bus.flush) begin
         foreach (pend[i]) pend[i] = 0;
         cnt = 0; mode = M_RUN;
      end else begin
         ok = bus.wb_valid && cnt > 0 && (bus.wb_dst_reg == 0 || pend[bus.wb_dst_reg]);
         if (bus.wb_valid && !ok) err_m = 1;
         if (ok) begin
            cnt--;
            if (bus.wb_dst_reg != 0) pend[bus.wb_dst_reg] = 0;
         end
         if (iss) begin
            cnt++;
            if (bus.dec_dst_reg != 0) pend[bus.dec_dst_reg] = 1;
         end
         case (mode)
            M_RUN:   if (bus.dec_valid && bus.dec_ecall) mode = iss ? M_EW : M_DRAIN;
            M_DRAIN: if (iss) mode = M_EW; else if (!(bus.dec_valid && bus.dec_ecall)) mode = M_RUN;
            default: if (cnt == 0) mode = M_RUN;
         endcase
      end
   endtask

   task automatic cycle();
      bit iss;
      #1;
      iss = m_issue();
      check("issue", bus.issue, iss);
      check("stall", bus.stall, bus.dec_valid & ~iss);
      @(posedge clk);
      m_step(iss);
      #1;
      check("pending_mask", bus.pending_mask, m_mask());
      check("inflight", bus.inflight, cnt);
      check("state", bus.state, mode);
      check("err", bus.err, err_m);
      @(negedge clk);
   endtask

   task automatic dec(input bit v, input int r1, input bit u1, input int r2, input bit u2, input int dst, input bit ec);
      bus.dec_valid = v; bus.dec_r1_reg = 5'(r1); bus.dec_uses_r1 = u1;
      bus.dec_r2_reg = 5'(r2); bus.dec_uses_r2 = u2; bus.dec_dst_reg = 5'(dst); bus.dec_ecall = ec;
   endtask

   task automatic wb(input bit v, input int dst);
      bus.wb_valid = v; bus.wb_dst_reg = 5'(dst);
   endtask

   task automatic do_reset();
      reset = 1'b1; cycle(); cycle(); reset = 1'b0;
   endtask

   initial begin
      int q[$];
      reset = 1'b1; bus.ex_ready = 1'b1; bus.flush = 1'b0;
      dec(1, 0, 0, 0, 0, 0, 0); wb(0, 0);
      cnt = 0; mode = M_RUN; err_m = 0;
      @(negedge clk);
      do_reset();
      check("reset_mask", bus.pending_mask, 32'h0);
      // RAW on x5
      dec(1, 0, 0, 0, 0, 5, 0); cycle();
      dec(1, 5, 1, 1, 1, 6, 0); cycle(); cycle();
      check("raw_mask", bus.pending_mask, 32'h20);
      wb(1, 5); cycle();
      wb(0, 0); cycle();
      check("raw_issued_mask", bus.pending_mask, 32'h40);
      dec(0, 0, 0, 0, 0, 0, 0); wb(1, 6); cycle(); wb(0, 0);
      // capacity limit
      for (int i = 1; i <= 4; i++) begin dec(1, 0, 0, 0, 0, i, 0); cycle(); end
      check("full_count", bus.inflight, 3'd4);
      dec(1, 0, 0, 0, 0, 7, 0); cycle();
      wb(1, 1); cycle();
      wb(0, 0); cycle();
      check("full_refill", bus.inflight, 3'd4);
      dec(0, 0, 0, 0, 0, 0, 0);
      foreach (q[i]) q.delete(i);
      for (int i = 2; i <= 4; i++) begin wb(1, i); cycle(); end
      wb(1, 7); cycle(); wb(0, 0);
      // ECALL drain
      dec(1, 0, 0, 0, 0, 1, 0); cycle();
      dec(1, 0, 0, 0, 0, 2, 0); cycle();
      dec(1, 0, 0, 0, 0, 0, 1); cycle();
      check("ecall_drain", bus.state, 2'd1);
      wb(1, 1); cycle();
      wb(1, 2); cycle();
      wb(0, 0); cycle();
      check("ecall_wait", bus.state, 2'd2);
      dec(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
      wb(1, 0); cycle(); wb(0, 0);
      check("ecall_done", bus.state, 2'd0);
      // flush with concurrent retire
      for (int i = 1; i <= 3; i++) begin dec(1, 0, 0, 0, 0, i, 0); cycle(); end
      dec(0, 0, 0, 0, 0, 0, 0);
      check("flush_pre_mask", bus.pending_mask, 32'h0E);
      bus.flush = 1'b1; wb(1, 1); cycle();
      bus.flush = 1'b0; wb(0, 0);
      check("flush_mask", bus.pending_mask, 32'h0);
      check("flush_err", bus.err, 1'b0);
      // protocol error and x0 destination
      wb(1, 9); cycle(); wb(0, 0);
      check("err_set", bus.err, 1'b1);
      dec(1, 0, 0, 0, 0, 0, 0); cycle(); dec(0, 0, 0, 0, 0, 0, 0);
      check("x0_inc", bus.inflight, 3'd1);
      wb(1, 0); cycle(); wb(0, 0); cycle();
      check("x0_dec", bus.inflight, 3'd0);
      check("err_sticky", bus.err, 1'b1);
      do_reset();
      check("err_cleared", bus.err, 1'b0);
      // random traffic
      for (int n = 0; n < 2000; n++) begin
         bit ec;
         reset = $urandom_range(0, 199) == 0;
         bus.flush = $urandom_range(0, 39) == 0;
         bus.ex_ready = $urandom_range(0, 4) != 0;
         ec = $urandom_range(0, 19) == 0;
         dec($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), ec ? 0 : $urandom_range(0, 7), ec);
         q.delete();
         for (int i = 1; i < 32; i++) if (pend[i]) q.push_back(i);
         if ($urandom_range(0, 9) < 4) begin
            if (q.size() > 0 && $urandom_range(0, 9) < 8) wb(1, q[$urandom_range(0, q.size() - 1)]);
            else wb(1, $urandom_range(0, 9) < 7 ? 0 : $urandom_range(0, 31));
         end else wb(0, 0);
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
